// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the FP-INT MAC weight path.
// Holds the word/precision widths, the precision-to-width decode and the
// serializer state encoding. FIFO-side consumers import the same decode so
// both ends agree on how many bits a word carries.
package mac_pkg;

   localparam int unsigned MAX_W  = 16;
   localparam int unsigned PREC_W = 4;

   typedef enum logic [0:0] {
      IDLE,
      SHIFT
   } state_t;

   // Precision 0 encodes a full 16-bit word; 1..15 are literal bit counts.
   function automatic logic [4:0] prec_to_width(input logic [PREC_W-1:0] precision);
      return (precision == '0) ? 5'd16 : {1'b0, precision};
   endfunction

endpackage

// File: rtl/int_bit_serializer_if.sv
// int_bit_serializer_if: word handshake and FIFO write-side bundle.
//   in_valid / in_ready / in_data / precision : upstream word handshake
//   fifo_full                                 : downstream back-pressure
//   fifo_wr_en / fifo_din / word_done          : serial write strobes
//   busy                                      : word shifting or pending
// master = word source / FIFO side, slave = serializer.
interface int_bit_serializer_if;
   import mac_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [MAX_W-1:0]  in_data;
   logic [PREC_W-1:0] precision;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic              fifo_din;
   logic              word_done;
   logic              busy;

   modport master (
      output in_valid, in_data, precision, fifo_full,
      input  in_ready, fifo_wr_en, fifo_din, word_done, busy
   );

   modport slave (
      input  in_valid, in_data, precision, fifo_full,
      output in_ready, fifo_wr_en, fifo_din, word_done, busy
   );

endinterface

// File: rtl/int_bit_serializer.sv
// int_bit_serializer: parallel weight word to LSB-first bit stream.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of int_bit_serializer_if (handshake in, FIFO strobes out)
// One word shifts out of r_sh while a second may wait in the pending buffer,
// so consecutive words stream with no idle cycle between them.
module int_bit_serializer
   import mac_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   int_bit_serializer_if.slave  bus
);

   state_t            r_state, w_state_nxt;
   logic [MAX_W-1:0]  r_sh, w_sh_nxt;
   logic [4:0]        r_bc, w_bc_nxt;
   logic [4:0]        r_w, w_w_nxt;
   logic [MAX_W-1:0]  r_pd, w_pd_nxt;
   logic [4:0]        r_pd_w, w_pd_w_nxt;
   logic              r_pd_v, w_pd_v_nxt;

   logic              w_accept;
   logic              w_strobe;
   logic              w_last;
   logic [4:0]        w_width_in;

   assign w_width_in = prec_to_width(bus.precision);
   // in_ready depends only on r_pd_v, so no in_valid -> in_ready path exists.
   assign w_accept   = bus.in_valid && !r_pd_v;
   assign w_strobe   = (r_state == SHIFT) && !bus.fifo_full;
   assign w_last     = w_strobe && (r_bc == (r_w - 5'd1));

   assign bus.in_ready   = !r_pd_v;
   assign bus.fifo_wr_en = w_strobe;
   assign bus.fifo_din   = r_sh[0];
   assign bus.word_done  = w_last;
   assign bus.busy       = (r_state == SHIFT) || r_pd_v;

   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_bc_nxt    = r_bc;
      w_w_nxt     = r_w;
      w_pd_nxt    = r_pd;
      w_pd_w_nxt  = r_pd_w;
      w_pd_v_nxt  = r_pd_v;

      if (w_strobe) begin
         w_sh_nxt = r_sh >> 1;
         w_bc_nxt = r_bc + 5'd1;
      end

      if (w_last) begin
         if (r_pd_v) begin
            // Pending word takes over directly: no bubble.
            w_sh_nxt   = r_pd;
            w_bc_nxt   = '0;
            w_w_nxt    = r_pd_w;
            w_pd_v_nxt = 1'b0;
         end else if (w_accept) begin
            // Word arriving on the last-bit edge bypasses the pending buffer.
            w_sh_nxt = bus.in_data;
            w_bc_nxt = '0;
            w_w_nxt  = w_width_in;
         end else begin
            // Clear leftover upper bits so fifo_din stays quiet while idle.
            w_state_nxt = IDLE;
            w_sh_nxt    = '0;
            w_bc_nxt    = '0;
         end
      end else if (w_accept) begin
         unique case (r_state)
            IDLE: begin
               w_state_nxt = SHIFT;
               w_sh_nxt    = bus.in_data;
               w_bc_nxt    = '0;
               w_w_nxt     = w_width_in;
            end
            SHIFT: begin
               w_pd_nxt   = bus.in_data;
               w_pd_w_nxt = w_width_in;
               w_pd_v_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_bc    <= '0;
         r_w     <= '0;
         r_pd    <= '0;
         r_pd_w  <= '0;
         r_pd_v  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_bc    <= w_bc_nxt;
         r_w     <= w_w_nxt;
         r_pd    <= w_pd_nxt;
         r_pd_w  <= w_pd_w_nxt;
         r_pd_v  <= w_pd_v_nxt;
      end
   end

endmodule
